// File: rtl/ntt_ctrl.sv
// Kyber NTT sequencing controller: walks 7 butterfly layers over 256 coefficients
// and emits a BF_LAT-delayed write-back stream. Define NTT_CTRL_INTT_EN for inverse mode + scaling.
module ntt_ctrl #(
  parameter int BF_LAT = 3,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
`ifdef NTT_CTRL_INTT_EN
  input  logic              i_mode,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic              o_bf_valid,
  output logic [1:0]        o_bf_op,
  output logic [ADDR_W-1:0] o_bf_addr_a,
  output logic [ADDR_W-1:0] o_bf_addr_b,
  output logic [6:0]        o_bf_zeta_idx,
  output logic              o_wb_en,
  output logic [ADDR_W-1:0] o_wb_addr_a,
  output logic [ADDR_W-1:0] o_wb_addr_b,
  output logic [1:0]        o_wb_op
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
`ifdef NTT_CTRL_INTT_EN
    S_SCALE,
    S_SDRAIN,
`endif
    S_DONE
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(BF_LAT - 1);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_layer, w_layer_nxt;
  logic [7:0]  r_idx, w_idx_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
`ifdef NTT_CTRL_INTT_EN
  logic        r_mode, w_mode_nxt;
`endif

  logic [6:0]  w_j;
  logic [7:0]  w_f_len, w_f_a, w_f_b;
  logic [6:0]  w_f_g, w_f_z;

  assign w_j = r_idx[6:0];

  // Cooley-Tukey: half-span shrinks 128 -> 2 as the layer advances
  assign w_f_len = 8'd128 >> r_layer;
  assign w_f_g   = w_j >> (3'd7 - r_layer);
  assign w_f_a   = ({1'b0, w_f_g} << (4'd8 - {1'b0, r_layer})) | ({1'b0, w_j} & (w_f_len - 8'd1));
  assign w_f_b   = w_f_a + w_f_len;
  assign w_f_z   = (7'd1 << r_layer) + w_f_g;

`ifdef NTT_CTRL_INTT_EN
  logic [7:0]  w_i_len, w_i_a, w_i_b;
  logic [6:0]  w_i_g, w_i_z;

  // Gentleman-Sande: half-span grows 2 -> 128, zetas walked backwards
  assign w_i_len = 8'd2 << r_layer;
  assign w_i_g   = w_j >> (r_layer + 3'd1);
  assign w_i_a   = ({1'b0, w_i_g} << ({1'b0, r_layer} + 4'd2)) | ({1'b0, w_j} & (w_i_len - 8'd1));
  assign w_i_b   = w_i_a + w_i_len;
  assign w_i_z   = 7'((8'd128 >> r_layer) - 8'd1 - {1'b0, w_i_g});
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_layer <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
`ifdef NTT_CTRL_INTT_EN
      r_mode  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_layer <= w_layer_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
`ifdef NTT_CTRL_INTT_EN
      r_mode  <= w_mode_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_layer_nxt = r_layer;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
`ifdef NTT_CTRL_INTT_EN
    w_mode_nxt  = r_mode;
`endif
    case (r_state)
      S_IDLE: begin
        w_layer_nxt = '0;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
`ifdef NTT_CTRL_INTT_EN
        w_mode_nxt  = i_mode;
`endif
        if (i_start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (r_idx == 8'd127) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 8'd1;
        end
      end
      // Hold off the next layer until the last write-back of this one has landed
      S_DRAIN: begin
        if (r_cnt == LAT_LAST) begin
          w_idx_nxt = '0;
          if (r_layer != 3'd6) begin
            w_layer_nxt = r_layer + 3'd1;
            w_state_nxt = S_RUN;
          end else begin
`ifdef NTT_CTRL_INTT_EN
            w_state_nxt = r_mode ? S_SCALE : S_DONE;
`else
            w_state_nxt = S_DONE;
`endif
          end
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
`ifdef NTT_CTRL_INTT_EN
      S_SCALE: begin
        if (r_idx == 8'hFF) begin
          w_state_nxt = S_SDRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 8'd1;
        end
      end
      S_SDRAIN: begin
        if (r_cnt == LAT_LAST) w_state_nxt = S_DONE;
        else                   w_cnt_nxt   = r_cnt + 4'd1;
      end
`endif
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy        = (r_state != S_IDLE);
    o_done        = (r_state == S_DONE);
    o_bf_valid    = 1'b0;
    o_bf_op       = 2'd0;
    o_bf_addr_a   = '0;
    o_bf_addr_b   = '0;
    o_bf_zeta_idx = '0;
    if (r_state == S_RUN) begin
      o_bf_valid    = 1'b1;
      o_bf_addr_a   = w_f_a;
      o_bf_addr_b   = w_f_b;
      o_bf_zeta_idx = w_f_z;
`ifdef NTT_CTRL_INTT_EN
      if (r_mode) begin
        o_bf_op       = 2'd1;
        o_bf_addr_a   = w_i_a;
        o_bf_addr_b   = w_i_b;
        o_bf_zeta_idx = w_i_z;
      end
`endif
    end
`ifdef NTT_CTRL_INTT_EN
    if (r_state == S_SCALE) begin
      o_bf_valid  = 1'b1;
      o_bf_op     = 2'd2;
      o_bf_addr_a = r_idx;
    end
`endif
  end

  logic              r_wb_vld_p [BF_LAT];
  logic [ADDR_W-1:0] r_wb_a_p   [BF_LAT];
  logic [ADDR_W-1:0] r_wb_b_p   [BF_LAT];
  logic [1:0]        r_wb_op_p  [BF_LAT];

  // Write-back delay line: free-running, mirrors the butterfly unit latency
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BF_LAT; i++) begin
        r_wb_vld_p[i] <= 1'b0;
        r_wb_a_p[i]   <= '0;
        r_wb_b_p[i]   <= '0;
        r_wb_op_p[i]  <= '0;
      end
    end else begin
      r_wb_vld_p[0] <= o_bf_valid;
      r_wb_a_p[0]   <= o_bf_addr_a;
      r_wb_b_p[0]   <= o_bf_addr_b;
      r_wb_op_p[0]  <= o_bf_op;
      for (int i = 1; i < BF_LAT; i++) begin
        r_wb_vld_p[i] <= r_wb_vld_p[i-1];
        r_wb_a_p[i]   <= r_wb_a_p[i-1];
        r_wb_b_p[i]   <= r_wb_b_p[i-1];
        r_wb_op_p[i]  <= r_wb_op_p[i-1];
      end
    end
  end

  assign o_wb_en     = r_wb_vld_p[BF_LAT-1];
  assign o_wb_addr_a = r_wb_a_p[BF_LAT-1];
  assign o_wb_addr_b = r_wb_b_p[BF_LAT-1];
  assign o_wb_op     = r_wb_op_p[BF_LAT-1];

endmodule
